// File: rtl/rand_req_arbiter_if.sv
// Request/result bundle between the game-logic requesters, the LFSR and rand_req_arbiter.
interface rand_req_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6
);
  logic [15:0]      rnd;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             busy;
  logic             lfsr_lock;

  modport master (
    output rnd, req,
    input  gnt, value, valid, busy, lfsr_lock
  );

  modport slave (
    input  rnd, req,
    output gnt, value, valid, busy, lfsr_lock
  );
endinterface

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter returning LFSR samples rejection-bounded to [0, LIMIT).
// Define RNG_RETRY_CAP_EN to fold (cand - LIMIT) after MAX_TRIES rejections instead of retrying forever.
module rand_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 6,
  parameter int LIMIT     = 40,
  parameter int MAX_TRIES = 8
) (
  input logic               clk,
  input logic               reset,
  rand_req_arbiter_if.slave bus
);
  localparam int                IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH:0]    LIMIT_W  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0]  LIMIT_N  = WIDTH'(LIMIT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ-1);

  if (NREQ < 2 || NREQ > 8) begin : gNreqCheck
    $error("rand_req_arbiter: NREQ must be 2..8");
  end
  if (LIMIT <= (1 << (WIDTH-1)) || LIMIT > (1 << WIDTH)) begin : gLimitCheck
    $error("rand_req_arbiter: LIMIT must satisfy 2^(WIDTH-1) < LIMIT <= 2^WIDTH");
  end
  if (MAX_TRIES < 1) begin : gTriesCheck
    $error("rand_req_arbiter: MAX_TRIES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] winIdx_q, winIdx_d;
  logic [IDX_W-1:0] winSel;
  logic             winFound;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] cand;
  logic             candOk;
  logic             lock_q, lock_d;
  logic             validW;
`ifdef RNG_RETRY_CAP_EN
  localparam int TRY_W = $clog2(MAX_TRIES+1);
  logic [TRY_W-1:0] tries_q, tries_d;
`endif

  assign cand   = bus.rnd[WIDTH-1:0];
  assign candOk = {1'b0, cand} < LIMIT_W;

  // Scan from the highest offset down so the nearest requester at/after rrPtr_q wins.
  always_comb begin : pickWinner
    int idx;
    logic [IDX_W-1:0] idxCut;
    winFound = 1'b0;
    winSel   = '0;
    idx      = 0;
    idxCut   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idxCut = IDX_W'(idx);
      if (bus.req[idxCut]) begin
        winFound = 1'b1;
        winSel   = idxCut;
      end
    end
  end

  always_comb begin : nextState
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    winIdx_d = winIdx_q;
    value_d  = value_q;
    lock_d   = lock_q | (bus.rnd == 16'hFFFF);
`ifdef RNG_RETRY_CAP_EN
    tries_d  = tries_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (winFound) begin
          winIdx_d = winSel;
`ifdef RNG_RETRY_CAP_EN
          tries_d  = '0;
`endif
          state_d  = SAMPLE;
        end
      end
      SAMPLE: begin
        if (!bus.req[winIdx_q]) begin
          state_d = IDLE;
        end else if (candOk) begin
          value_d = cand;
          state_d = DONE;
        end
`ifdef RNG_RETRY_CAP_EN
        else if (tries_q == TRY_W'(MAX_TRIES-1)) begin
          value_d = cand - LIMIT_N;
          state_d = DONE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
`endif
      end
      DONE: begin
        rrPtr_d = (winIdx_q == LAST_IDX) ? '0 : winIdx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      winIdx_q <= '0;
      value_q  <= '0;
      lock_q   <= 1'b0;
`ifdef RNG_RETRY_CAP_EN
      tries_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      winIdx_q <= winIdx_d;
      value_q  <= value_d;
      lock_q   <= lock_d;
`ifdef RNG_RETRY_CAP_EN
      tries_q  <= tries_d;
`endif
    end
  end

  // Every output decodes registered state only; nothing flows through from req or rnd.
  assign validW        = (state_q == DONE);
  assign bus.valid     = validW;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt       = validW ? (NREQ'(1) << winIdx_q) : '0;
  assign bus.value     = value_q;
  assign bus.lfsr_lock = lock_q;
endmodule

// File: tb/tb_rand_req_arbiter.sv
// Self-checking bench for rand_req_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_rand_req_arbiter;
  localparam int NREQ      = 4;
  localparam int WIDTH     = 6;
  localparam int LIMIT     = 40;
  localparam int MAX_TRIES = 8;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;

  // Model: mOwner is the requester being served (-1 when none), mGranting marks the result cycle.
  int   mOwner    = -1;
  bit   mGranting = 1'b0;
  int   mPtr      = 0;
  int   mValue    = 0;
  bit   mLock     = 1'b0;
  int   mTries    = 0;

  rand_req_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  rand_req_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .LIMIT(LIMIT), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic modelStep(input logic [15:0] r, input logic [NREQ-1:0] q, input logic rst);
    int cand;
    if (rst) begin
      mOwner = -1; mGranting = 1'b0; mPtr = 0; mValue = 0; mLock = 1'b0; mTries = 0;
      return;
    end
    if (r == 16'hFFFF) mLock = 1'b1;
    cand = int'(r) % (1 << WIDTH);
    if (mGranting) begin
      mPtr      = (mOwner + 1) % NREQ;
      mGranting = 1'b0;
      mOwner    = -1;
    end else if (mOwner < 0) begin
      for (int k = NREQ-1; k >= 0; k--)
        if (q[(mPtr + k) % NREQ]) mOwner = (mPtr + k) % NREQ;
      mTries = 0;
    end else if (!q[mOwner]) begin
      mOwner = -1;
    end else if (cand < LIMIT) begin
      mValue    = cand;
      mGranting = 1'b1;
    end else begin
`ifdef RNG_RETRY_CAP_EN
      if (mTries == MAX_TRIES-1) begin
        mValue    = cand - LIMIT;
        mGranting = 1'b1;
      end else begin
        mTries++;
      end
`endif
    end
  endtask

  // One clock: present inputs, let the edge happen, then compare all outputs against the model.
  task automatic applyStimulus(input logic [15:0] r, input logic [NREQ-1:0] q, input logic rst);
    bus.rnd = r;
    bus.req = q;
    reset   = rst;
    @(posedge clk);
    modelStep(r, q, rst);
    #1;
    checkOutput("valid", bus.valid, mGranting);
    checkOutput("gnt", bus.gnt, mGranting ? (32'd1 << mOwner) : 32'd0);
    checkOutput("busy", bus.busy, mOwner >= 0);
    checkOutput("value", bus.value, mValue);
    checkOutput("lfsrLock", bus.lfsr_lock, mLock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gAt[4];
    logic [NREQ-1:0] gVal[4];
    logic [NREQ-1:0] gExp[4];
    int gCount;
    int firstValid;
    int validSeen;
    logic [NREQ-1:0] rq;
    logic [15:0] rr;

    bus.rnd = '0;
    bus.req = '0;
    reset   = 1'b1;

    applyStimulus(16'h0000, 4'b0000, 1'b1);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstValue", bus.value, 0);

    // Single request, minimum latency.
    applyStimulus(16'h0005, 4'b0001, 1'b0);
    checkOutput("singleBusy", bus.busy, 1);
    checkOutput("singleEarlyValid", bus.valid, 0);
    applyStimulus(16'h0005, 4'b0001, 1'b0);
    checkOutput("singleValid", bus.valid, 1);
    checkOutput("singleGnt", bus.gnt, 4'b0001);
    checkOutput("singleValue", bus.value, 5);
    applyStimulus(16'h0005, 4'b0000, 1'b0);
    checkOutput("singleIdle", bus.busy, 0);
    checkOutput("singleValidDrop", bus.valid, 0);

    // Requester 1 drops while being rejected; pointer must stay at 1.
    applyStimulus(16'h00FF, 4'b0010, 1'b0);
    applyStimulus(16'h00FF, 4'b0010, 1'b0);
    applyStimulus(16'h00FF, 4'b0000, 1'b0);
    checkOutput("dropBusy", bus.busy, 0);
    checkOutput("dropValid", bus.valid, 0);
    applyStimulus(16'h0000, 4'b0011, 1'b0);
    applyStimulus(16'h0000, 4'b0011, 1'b0);
    checkOutput("dropRegrantGnt", bus.gnt, 4'b0010);
    applyStimulus(16'h0000, 4'b0000, 1'b0);

    // Contention with 1011 held: round-robin order and 3-cycle spacing.
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    gCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h0000, 4'b1011, 1'b0);
      if (bus.valid === 1'b1 && gCount < 4) begin
        gAt[gCount]  = i;
        gVal[gCount] = bus.gnt;
        gCount++;
      end
    end
    gExp[0] = 4'b0001; gExp[1] = 4'b0010; gExp[2] = 4'b1000; gExp[3] = 4'b0001;
    checkOutput("contCount", gCount, 4);
    for (int i = 0; i < gCount; i++) begin
      checkOutput("contGnt", gVal[i], gExp[i]);
      if (i > 0) checkOutput("contGap", gAt[i] - gAt[i-1], 3);
    end

    // Rejections: low bits 63, 50, then 12 accepted.
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    applyStimulus(16'h0000, 4'b0100, 1'b0);
    applyStimulus(16'h12FF, 4'b0100, 1'b0);
    checkOutput("rejValid63", bus.valid, 0);
    applyStimulus(16'h3472, 4'b0100, 1'b0);
    checkOutput("rejValid50", bus.valid, 0);
    applyStimulus(16'h560C, 4'b0100, 1'b0);
    checkOutput("rejValid", bus.valid, 1);
    checkOutput("rejValue", bus.value, 12);
    checkOutput("rejGnt", bus.gnt, 4'b0100);

    // Low bits stuck at 45: folds after MAX_TRIES when capped, otherwise waits for a good sample.
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    firstValid = -1;
    validSeen  = 0;
`ifdef RNG_RETRY_CAP_EN
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h002D, 4'b0001, 1'b0);
      if (bus.valid === 1'b1 && firstValid < 0) begin
        firstValid = i;
        checkOutput("capValue", bus.value, 5);
      end
    end
    checkOutput("capLatency", firstValid, MAX_TRIES);
`else
    for (int i = 0; i < 12; i++) begin
      applyStimulus(16'h002D, 4'b0001, 1'b0);
      if (bus.valid === 1'b1) validSeen++;
    end
    checkOutput("uncappedNoValid", validSeen, 0);
    applyStimulus(16'h0003, 4'b0001, 1'b0);
    checkOutput("uncappedValid", bus.valid, 1);
    checkOutput("uncappedValue", bus.value, 3);
`endif
    applyStimulus(16'h0000, 4'b0000, 1'b0);

    // Lock-up flag is sticky; reset mid-SAMPLE clears everything.
    applyStimulus(16'h0007, 4'b0001, 1'b0);
    applyStimulus(16'h0007, 4'b0001, 1'b0);
    applyStimulus(16'hFFFF, 4'b0000, 1'b0);
    checkOutput("lockSet", bus.lfsr_lock, 1);
    applyStimulus(16'h1234, 4'b0000, 1'b0);
    checkOutput("lockSticky", bus.lfsr_lock, 1);
    applyStimulus(16'h00FF, 4'b0001, 1'b0);
    applyStimulus(16'h00FF, 4'b0001, 1'b0);
    applyStimulus(16'h00FF, 4'b0001, 1'b1);
    checkOutput("midRstLock", bus.lfsr_lock, 0);
    checkOutput("midRstValid", bus.valid, 0);
    checkOutput("midRstGnt", bus.gnt, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstValue", bus.value, 0);
    applyStimulus(16'h0000, 4'b0000, 1'b0);
    checkOutput("postRstIdle", bus.busy, 0);

    // Randomized traffic with occasional lock-up words and resets.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0) rq = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rr = 16'($urandom);
      if ($urandom_range(0, 49) == 0) rr = 16'hFFFF;
      applyStimulus(rr, rq, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
